rcc_scan_ctrl: RTL and testbench
================================

Name: rcc_scan_ctrl

Overview:
Controller that sequences a multi-digit result conversion onto the character output bus.
- Accepts a packed BCD result word through a valid/ready handshake.
- Emits one ASCII character per digit slot, most-significant digit first. Each character is qualified by a digit_clk pulse, and dout_flag is low while a conversion is in flight.
- Sits between the result producer and the character/display sink.
- Owns the dout/dout_flag idle conventions: dout = 8'hFF and dout_flag = 1 when idle.

Parameters:
- NUM_DIGITS, 4, number of BCD digits per result (2..8).
- DIGIT_DIV, 8, clk cycles per digit slot; must be even and >= 4.
- BLANK_LEADING, 1, 1 = leading zeros are emitted as space (8'h20); the least-significant digit is never blanked.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- res_valid, input, 1, producer has a result available.
- res_data, input, 4*NUM_DIGITS, packed BCD; MSD in the top nibble.
- res_ready, output, 1, block can accept a result.
- dout, output, 8, ASCII character for the current slot; 8'hFF when idle.
- dout_flag, output, 1, 1 = idle/no valid char; 0 = conversion in progress.
- digit_clk, output, 1, strobe qualifying dout within each slot.
- digit_sel, output, $clog2(NUM_DIGITS), index of the current digit (NUM_DIGITS-1 = MSD).
- err, output, 1, sticky: a non-BCD nibble (>9) was encountered in the current/last result.

Behaviour:
- Reset (async assert, sync release) values: dout = 8'hFF, dout_flag = 1, digit_clk = 0, digit_sel = NUM_DIGITS-1, res_ready = 1, err = 0. FSM goes to IDLE; slot and digit counters clear.
- FSM states: IDLE, EMIT, DONE.
- IDLE:
  - res_ready = 1.
  - On res_valid && res_ready at an edge: latch res_data, clear err, go to EMIT. digit_sel = NUM_DIGITS-1 and slot counter = 0.
- EMIT:
  - res_ready = 0. Slot counter runs 0..DIGIT_DIV-1.
  - Slot cycle 0: dout updates to the encoded char of the digit_sel nibble; dout_flag = 0.
  - Slot cycles 1..DIGIT_DIV/2: digit_clk = 1.
  - Remaining slot cycles: digit_clk = 0.
  - dout is stable for the whole slot, so it is valid at least one cycle before digit_clk rises.
  - At the end of a slot, if digit_sel == 0, go to DONE; otherwise decrement digit_sel.
- DONE (one cycle): dout = 8'hFF, dout_flag = 1, digit_clk = 0, digit_sel = NUM_DIGITS-1, go to IDLE.
- Accept-to-first-char latency: dout and dout_flag change at the edge one cycle after the handshake edge.
- Busy time: NUM_DIGITS*DIGIT_DIV + 1 cycles before res_ready is 1 again.
- Encoding:
  - Nibble 0..9 -> 8'h30 + nibble.
  - Nibble > 9 -> 8'h3F ('?') and err is set (sticky until the next acceptance).
  - Blanking: while BLANK_LEADING = 1 and all more-significant nibbles, including the current one, are zero, emit 8'h20. digit_sel == 0 is always encoded.
  - A non-BCD nibble ends the blanking run.
- Boundary conditions:
  - res_valid while busy is ignored and not latched; res_data changes while busy have no effect.
  - res_valid held high continuously: the next acceptance occurs in the IDLE cycle after DONE.
  - Reset mid-EMIT: outputs immediately take their reset values (async); the partial result is discarded and no further digit_clk pulses occur.
- digit_clk and dout must be glitch-free: driven from registers.

Decomposition:
- Package rcc_pkg:
  - State enum type rcc_scan_state_t {IDLE, EMIT, DONE}.
  - Constants DOUT_IDLE = 8'hFF, CHAR_BLANK = 8'h20, CHAR_ERR = 8'h3F, CHAR_ZERO = 8'h30.
  - Function bcd_to_ascii(nibble, blank) returning the 8-bit char.
- One sub-module: rcc_char_enc, a combinational nibble + blank-flag -> ASCII + invalid flag encoder, instanced once. FSM, counters and blanking tracking stay in rcc_scan_ctrl.

Test Plan:
1. Defaults, res_data = 16'h1234, one handshake:
   - dout sequence 8'h31, 8'h32, 8'h33, 8'h34, each with exactly one 4-cycle digit_clk pulse.
   - dout_flag low for 32 cycles, then dout = 8'hFF and dout_flag = 1.
   - err = 0; res_ready high again 33 cycles after the handshake.
2. Leading-zero blanking:
   - res_data = 16'h0050 -> 8'h20, 8'h20, 8'h35, 8'h30.
   - res_data = 16'h0000 -> 8'h20, 8'h20, 8'h20, 8'h30.
   - With BLANK_LEADING = 0, 16'h0050 -> 8'h30, 8'h30, 8'h35, 8'h30.
3. Invalid BCD, res_data = 16'h12A4:
   - dout 8'h31, 8'h32, 8'h3F, 8'h34; err rises with the third char and stays 1 after DONE.
   - The next valid result 16'h5678 clears err on acceptance.
4. Back-to-back:
   - res_valid held high with 16'h1111, then 16'h2222 presented while busy.
   - 16'h2222 is not accepted until res_ready returns; exactly 8 digit_clk pulses in total.
   - No overlap between the two sequences; dout = 8'hFF for the DONE cycle in between.
5. Reset asserted mid-slot during the 2nd digit of 16'h9876:
   - dout = 8'hFF, dout_flag = 1, digit_clk = 0 without waiting for a clk edge.
   - After release, res_ready = 1 and a new 16'h0001 emits 8'h20, 8'h20, 8'h20, 8'h31.
6. Throughout all tests (checked by an assertion), with NUM_DIGITS = 2 and DIGIT_DIV = 4 as well:
   - dout is never unknown and is stable while digit_clk = 1.
   - digit_clk never pulses while dout_flag = 1.

Source files
------------

// File: rtl/rcc_pkg.sv
// rtl/rcc_pkg.sv - scan controller state type, character constants and BCD-to-ASCII encode
package rcc_pkg;

  typedef enum logic [1:0] {IDLE, EMIT, DONE} rcc_scan_state_t;

  localparam logic [7:0] DOUT_IDLE  = 8'hFF;
  localparam logic [7:0] CHAR_BLANK = 8'h20;
  localparam logic [7:0] CHAR_ERR   = 8'h3F;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;

  // A non-BCD nibble always shows as '?', even inside a blanking run.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nibble, input logic blank);
    logic [7:0] c;
    if (nibble > 4'd9) c = CHAR_ERR;
    else if (blank && (nibble == 4'd0)) c = CHAR_BLANK;
    else c = CHAR_ZERO + {4'h0, nibble};
    return c;
  endfunction

endpackage

// File: rtl/rcc_char_enc.sv
// rtl/rcc_char_enc.sv - combinational nibble + blank flag to ASCII character and invalid flag
module rcc_char_enc
  import rcc_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] char_code,
  output logic       invalid
);

  always_comb begin
    char_code = bcd_to_ascii(nibble, blank);
    invalid   = (nibble > 4'd9);
  end

endmodule

// File: rtl/rcc_scan_ctrl.sv
// rtl/rcc_scan_ctrl.sv - sequences a packed BCD result onto the character bus, MSD first
module rcc_scan_ctrl
  import rcc_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int DIGIT_DIV     = 8,
  parameter int BLANK_LEADING = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          res_valid,
  input  logic [4*NUM_DIGITS-1:0]       res_data,
  output logic                          res_ready,
  output logic [7:0]                    dout,
  output logic                          dout_flag,
  output logic                          digit_clk,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic                          err
);

  localparam int SLOT_W = $clog2(DIGIT_DIV);
  localparam int SEL_W  = $clog2(NUM_DIGITS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(DIGIT_DIV / 2);
  localparam logic [SEL_W-1:0]  SEL_MSD   = SEL_W'(NUM_DIGITS - 1);

  rcc_scan_state_t             state_q, state_d;
  logic [SLOT_W-1:0]           slot_q, slot_d;
  logic [SEL_W-1:0]            sel_d;
  logic [4*NUM_DIGITS-1:0]     data_q, data_d;
  logic                        blank_q, blank_d;
  logic [7:0]                  dout_d;
  logic                        flag_d, dclk_d, err_d;

  logic [3:0] cur_nibble;
  logic [7:0] enc_char;
  logic       enc_invalid;

  // The latched word shifts left each digit, so the current digit is always the top nibble.
  assign cur_nibble = data_q[4*NUM_DIGITS-1 -: 4];
  assign res_ready  = (state_q == IDLE);

  rcc_char_enc u_enc (
    .nibble    (cur_nibble),
    .blank     (blank_q && (digit_sel != '0)),
    .char_code (enc_char),
    .invalid   (enc_invalid)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sel_d   = digit_sel;
    data_d  = data_q;
    blank_d = blank_q;
    dout_d  = dout;
    flag_d  = dout_flag;
    dclk_d  = 1'b0;
    err_d   = err;
    case (state_q)
      IDLE: begin
        if (res_valid) begin
          state_d = EMIT;
          data_d  = res_data;
          err_d   = 1'b0;
          blank_d = (BLANK_LEADING != 0);
          sel_d   = SEL_MSD;
          slot_d  = '0;
        end
      end
      EMIT: begin
        // Outputs are registered, so the visible slot trails the counter by one cycle
        // and dout leads the digit_clk rise by a full cycle.
        dclk_d = (slot_q != '0) && (slot_q <= SLOT_HALF);
        if (slot_q == '0) begin
          dout_d  = enc_char;
          flag_d  = 1'b0;
          err_d   = err | enc_invalid;
          blank_d = blank_q && (cur_nibble == 4'd0);
        end
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          data_d = data_q << 4;
          if (digit_sel == '0) begin
            state_d = DONE;
            sel_d   = SEL_MSD;
          end else begin
            sel_d = digit_sel - 1'b1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      DONE: begin
        dout_d  = DOUT_IDLE;
        flag_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      digit_sel <= SEL_MSD;
      data_q    <= '0;
      blank_q   <= 1'b0;
      dout      <= DOUT_IDLE;
      dout_flag <= 1'b1;
      digit_clk <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      digit_sel <= sel_d;
      data_q    <= data_d;
      blank_q   <= blank_d;
      dout      <= dout_d;
      dout_flag <= flag_d;
      digit_clk <= dclk_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_rcc_scan_ctrl.sv
// tb/tb_rcc_scan_ctrl.sv - scoreboard bench for rcc_scan_ctrl (default, unblanked and 2-digit builds)
module tb_rcc_scan_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        res_valid = 1'b0;
  logic [15:0] res_data = '0;
  logic        res_ready, dout_flag, digit_clk, err;
  logic [7:0]  dout;
  logic [1:0]  digit_sel;

  logic        nb_valid = 1'b0;
  logic [15:0] nb_data = '0;
  logic        nb_ready, nb_flag, nb_dclk, nb_err;
  logic [7:0]  nb_dout;
  logic [1:0]  nb_sel;

  logic        sm_valid = 1'b0;
  logic [7:0]  sm_data = '0;
  logic        sm_ready, sm_flag, sm_dclk, sm_err;
  logic [7:0]  sm_dout;
  logic [0:0]  sm_sel;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$], obs_q[$], exp_nb_q[$], obs_nb_q[$], exp_sm_q[$], obs_sm_q[$];
  logic dclk_prev = 1'b0, nb_prev = 1'b0, sm_prev = 1'b0;

  always #5 clk = ~clk;

  rcc_scan_ctrl dut (
    .clk(clk), .reset(reset), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .dout(dout), .dout_flag(dout_flag), .digit_clk(digit_clk), .digit_sel(digit_sel), .err(err)
  );

  rcc_scan_ctrl #(.BLANK_LEADING(0)) dut_nb (
    .clk(clk), .reset(reset), .res_valid(nb_valid), .res_data(nb_data), .res_ready(nb_ready),
    .dout(nb_dout), .dout_flag(nb_flag), .digit_clk(nb_dclk), .digit_sel(nb_sel), .err(nb_err)
  );

  rcc_scan_ctrl #(.NUM_DIGITS(2), .DIGIT_DIV(4)) dut_sm (
    .clk(clk), .reset(reset), .res_valid(sm_valid), .res_data(sm_data), .res_ready(sm_ready),
    .dout(sm_dout), .dout_flag(sm_flag), .digit_clk(sm_dclk), .digit_sel(sm_sel), .err(sm_err)
  );

  // Capture the character presented at every digit_clk rising edge.
  always @(negedge clk) begin
    if (digit_clk && !dclk_prev) obs_q.push_back(dout);
    if (nb_dclk && !nb_prev) obs_nb_q.push_back(nb_dout);
    if (sm_dclk && !sm_prev) obs_sm_q.push_back(sm_dout);
    dclk_prev <= digit_clk;
    nb_prev   <= nb_dclk;
    sm_prev   <= sm_dclk;
  end

  a_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(dout)) else $error("FAIL assert dout unknown");
  a_stable: assert property (@(posedge clk) disable iff (reset) digit_clk |-> $stable(dout)) else $error("FAIL assert dout moved under digit_clk");
  a_flag: assert property (@(posedge clk) disable iff (reset) digit_clk |-> !dout_flag) else $error("FAIL assert digit_clk while idle");
  a_nb_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(nb_dout)) else $error("FAIL assert nb dout unknown");
  a_nb_stable: assert property (@(posedge clk) disable iff (reset) nb_dclk |-> $stable(nb_dout)) else $error("FAIL assert nb dout moved");
  a_nb_flag: assert property (@(posedge clk) disable iff (reset) nb_dclk |-> !nb_flag) else $error("FAIL assert nb digit_clk while idle");
  a_sm_known: assert property (@(posedge clk) disable iff (reset) !$isunknown(sm_dout)) else $error("FAIL assert sm dout unknown");
  a_sm_stable: assert property (@(posedge clk) disable iff (reset) sm_dclk |-> $stable(sm_dout)) else $error("FAIL assert sm dout moved");
  a_sm_flag: assert property (@(posedge clk) disable iff (reset) sm_dclk |-> !sm_flag) else $error("FAIL assert sm digit_clk while idle");

  task automatic send(input logic [15:0] d, input logic [31:0] chars);
    res_valid = 1'b1;
    res_data  = d;
    for (int i = 3; i >= 0; i--) exp_q.push_back(chars[i*8 +: 8]);
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic send_nb(input logic [15:0] d, input logic [31:0] chars);
    nb_valid = 1'b1;
    nb_data  = d;
    for (int i = 3; i >= 0; i--) exp_nb_q.push_back(chars[i*8 +: 8]);
    @(posedge clk);
    @(negedge clk);
    nb_valid = 1'b0;
  endtask

  task automatic send_sm(input logic [7:0] d, input logic [15:0] chars);
    sm_valid = 1'b1;
    sm_data  = d;
    for (int i = 1; i >= 0; i--) exp_sm_q.push_back(chars[i*8 +: 8]);
    @(posedge clk);
    @(negedge clk);
    sm_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (dout !== 8'hFF) begin bad++; $display("FAIL reset_dout got=%h want=ff", dout); end
    total++; if (dout_flag !== 1'b1) begin bad++; $display("FAIL reset_flag got=%b want=1", dout_flag); end
    total++; if (digit_clk !== 1'b0) begin bad++; $display("FAIL reset_dclk got=%b want=0", digit_clk); end
    total++; if (digit_sel !== 2'd3) begin bad++; $display("FAIL reset_sel got=%0d want=3", digit_sel); end
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", res_ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (sm_sel !== 1'b1) begin bad++; $display("FAIL reset_sm_sel got=%0d want=1", sm_sel); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int low_cnt = 0;
    int run = 0;
    int pulses = 0;
    logic [7:0] e, o;
    send(16'h1234, 32'h31323334);
    for (int k = 0; k <= 40; k++) begin
      if (!dout_flag) low_cnt++;
      if (digit_clk) run++;
      else if (run != 0) begin
        pulses++;
        total++; if (run !== 4) begin bad++; $display("FAIL basic_pulse_width got=%0d want=4", run); end
        run = 0;
      end
      if (k == 32) begin
        total++; if (res_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_early got=%b want=0", res_ready); end
      end
      if (k == 33) begin
        total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b want=1", res_ready); end
        total++; if (dout !== 8'hFF) begin bad++; $display("FAIL basic_idle_dout got=%h want=ff", dout); end
        total++; if (dout_flag !== 1'b1) begin bad++; $display("FAIL basic_idle_flag got=%b want=1", dout_flag); end
        total++; if (digit_sel !== 2'd3) begin bad++; $display("FAIL basic_idle_sel got=%0d want=3", digit_sel); end
      end
      @(negedge clk);
    end
    total++; if (low_cnt !== 32) begin bad++; $display("FAIL basic_flag_low got=%0d want=32", low_cnt); end
    total++; if (pulses !== 4) begin bad++; $display("FAIL basic_pulses got=%0d want=4", pulses); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", err); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL basic_char got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_blank();
    logic [7:0] e, o;
    send(16'h0050, 32'h20203530);
    send_nb(16'h0050, 32'h30303530);
    repeat (35) @(negedge clk);
    send(16'h0000, 32'h20202030);
    repeat (35) @(negedge clk);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL blank_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL blank_char got=%h want=%h", o, e); end
    end
    total++; if (obs_nb_q.size() != exp_nb_q.size()) begin bad++; $display("FAIL noblank_count got=%0d want=%0d", obs_nb_q.size(), exp_nb_q.size()); end
    while (exp_nb_q.size() > 0 && obs_nb_q.size() > 0) begin
      e = exp_nb_q.pop_front(); o = obs_nb_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL noblank_char got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); exp_nb_q.delete(); obs_nb_q.delete();
  endtask

  task automatic test_invalid();
    logic [7:0] e, o;
    send(16'h12A4, 32'h31323F34);
    for (int k = 0; k <= 34; k++) begin
      if (k == 16) begin
        total++; if (err !== 1'b0) begin bad++; $display("FAIL inv_err_early got=%b want=0", err); end
      end
      if (k == 17) begin
        total++; if (err !== 1'b1) begin bad++; $display("FAIL inv_err_rise got=%b want=1", err); end
      end
      if (k == 34) begin
        total++; if (err !== 1'b1) begin bad++; $display("FAIL inv_err_sticky got=%b want=1", err); end
      end
      @(negedge clk);
    end
    send(16'h5678, 32'h35363738);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL inv_err_clear got=%b want=0", err); end
    repeat (35) @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL inv_err_after got=%b want=0", err); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL inv_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL inv_char got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, o;
    res_valid = 1'b1;
    res_data  = 16'h1111;
    repeat (4) exp_q.push_back(8'h31);
    repeat (4) exp_q.push_back(8'h32);
    @(posedge clk);
    @(negedge clk);
    res_data = 16'h2222;
    for (int k = 0; k <= 33; k++) begin
      if (k == 16 || k == 32) begin
        total++; if (res_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_busy got=%b want=0", res_ready); end
      end
      if (k == 33) begin
        total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_gap got=%b want=1", res_ready); end
        total++; if (dout !== 8'hFF) begin bad++; $display("FAIL b2b_gap_dout got=%h want=ff", dout); end
        total++; if (dout_flag !== 1'b1) begin bad++; $display("FAIL b2b_gap_flag got=%b want=1", dout_flag); end
      end
      @(negedge clk);
    end
    total++; if (res_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b want=0", res_ready); end
    total++; if (dout !== 8'hFF) begin bad++; $display("FAIL b2b_gap2_dout got=%h want=ff", dout); end
    res_valid = 1'b0;
    repeat (36) @(negedge clk);
    total++; if (obs_q.size() != 8) begin bad++; $display("FAIL b2b_pulses got=%0d want=8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL b2b_char got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] e, o;
    res_valid = 1'b1;
    res_data  = 16'h9876;
    exp_q.push_back(8'h39);
    exp_q.push_back(8'h38);
    @(posedge clk);
    @(negedge clk);
    res_valid = 1'b0;
    repeat (11) @(negedge clk);
    total++; if (digit_clk !== 1'b1) begin bad++; $display("FAIL mid_dclk_before got=%b want=1", digit_clk); end
    reset = 1'b1;
    #1;
    total++; if (dout !== 8'hFF) begin bad++; $display("FAIL mid_dout got=%h want=ff", dout); end
    total++; if (dout_flag !== 1'b1) begin bad++; $display("FAIL mid_flag got=%b want=1", dout_flag); end
    total++; if (digit_clk !== 1'b0) begin bad++; $display("FAIL mid_dclk got=%b want=0", digit_clk); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", res_ready); end
    send(16'h0001, 32'h20202031);
    repeat (35) @(negedge clk);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL mid_char got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_small();
    logic [7:0] e, o;
    send_sm(8'h42, 16'h3432);
    for (int k = 0; k <= 9; k++) begin
      if (k == 8) begin
        total++; if (sm_ready !== 1'b0) begin bad++; $display("FAIL sm_ready_busy got=%b want=0", sm_ready); end
      end
      if (k == 9) begin
        total++; if (sm_ready !== 1'b1) begin bad++; $display("FAIL sm_ready_back got=%b want=1", sm_ready); end
        total++; if (sm_dout !== 8'hFF) begin bad++; $display("FAIL sm_idle_dout got=%h want=ff", sm_dout); end
      end
      @(negedge clk);
    end
    send_sm(8'h05, 16'h2035);
    repeat (10) @(negedge clk);
    send_sm(8'h00, 16'h2030);
    repeat (10) @(negedge clk);
    send_sm(8'h9A, 16'h393F);
    repeat (10) @(negedge clk);
    total++; if (sm_err !== 1'b1) begin bad++; $display("FAIL sm_err got=%b want=1", sm_err); end
    total++; if (obs_sm_q.size() != exp_sm_q.size()) begin bad++; $display("FAIL sm_count got=%0d want=%0d", obs_sm_q.size(), exp_sm_q.size()); end
    while (exp_sm_q.size() > 0 && obs_sm_q.size() > 0) begin
      e = exp_sm_q.pop_front(); o = obs_sm_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL sm_char got=%h want=%h", o, e); end
    end
    exp_sm_q.delete(); obs_sm_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
